dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer for the 16x8 data memory.
- The CPU core (port 0) and the program/debug loader (port 1) share the memory through this block.
- Each request becomes a correctly timed memory write or read cycle on the memory's address, r/w strobes and shared tri-state data bus.
- The block returns read data and a done pulse to the requester that owns the transaction.

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side signal bundle for the two-port data-memory arbiter.
// Port 0 is the CPU core, port 1 the program/debug loader.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0_i;
  logic              we0_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [DATA_W-1:0] wdata0_i;
  logic              gnt0_o;
  logic              done0_o;
  logic [DATA_W-1:0] rdata0_o;

  logic              req1_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              gnt1_o;
  logic              done1_o;
  logic [DATA_W-1:0] rdata1_o;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    output gnt0_o, done0_o, rdata0_o,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    output gnt1_o, done1_o, rdata1_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    input  gnt0_o, done0_o, rdata0_o,
    output req1_i, we1_i, addr1_i, wdata1_i,
    input  gnt1_o, done1_o, rdata1_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and cycle sequencer sharing the 16x8 data memory
// between two requesters over an address, r/w strobes and a tri-state bus.
module dmem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  dmem_arbiter_if.slave     req_if,
  output logic [ADDR_W-1:0] mem_add_o,
  output logic              mem_r_o,
  output logic              mem_w_o,
  inout  wire  [DATA_W-1:0] mem_data_io
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_bus_oe;
  logic [ADDR_W-1:0] r_mem_add;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic              r_mem_r;
  logic              r_mem_w;

  logic              w_any_req;
  logic              w_pick1;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the port that was not granted last wins.
  assign w_any_req = req_if.req0_i | req_if.req1_i;
  assign w_pick1   = req_if.req1_i & (~req_if.req0_i | ~r_last_grant);
  assign w_we      = w_pick1 ? req_if.we1_i    : req_if.we0_i;
  assign w_addr    = w_pick1 ? req_if.addr1_i  : req_if.addr0_i;
  assign w_wdata   = w_pick1 ? req_if.wdata1_i : req_if.wdata0_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_bus_oe     <= 1'b0;
      r_mem_add    <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_mem_r      <= 1'b0;
      r_mem_w      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_pick1;
            r_last_grant <= w_pick1;
            r_gnt0       <= ~w_pick1;
            r_gnt1       <= w_pick1;
            r_mem_add    <= w_addr;
            r_wdata      <= w_wdata;
            if (w_we) begin
              r_state  <= S_WRITE;
              r_mem_w  <= 1'b1;
              r_bus_oe <= 1'b1;
            end else begin
              r_state <= S_RD_ADDR;
              r_mem_r <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_mem_w  <= 1'b0;
          r_bus_oe <= 1'b0;
          r_done0  <= ~r_owner;
          r_done1  <= r_owner;
          r_state  <= S_DONE;
        end
        S_RD_ADDR: begin
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          // The memory is driving the bus during this cycle.
          if (r_owner) begin
            r_rdata1 <= mem_data_io;
          end else begin
            r_rdata0 <= mem_data_io;
          end
          r_mem_r <= 1'b0;
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_data_io     = r_bus_oe ? r_wdata : {DATA_W{1'bz}};
  assign mem_add_o       = r_mem_add;
  assign mem_r_o         = r_mem_r;
  assign mem_w_o         = r_mem_w;
  assign req_if.gnt0_o   = r_gnt0;
  assign req_if.gnt1_o   = r_gnt1;
  assign req_if.done0_o  = r_done0;
  assign req_if.done1_o  = r_done1;
  assign req_if.rdata0_o = r_rdata0;
  assign req_if.rdata1_o = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 16x8 memory on the shared bus,
// transaction scoreboard checked on every done pulse, per-cycle bus rules.
module tb_dmem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       mem_rst;
  logic [3:0] mem_add;
  logic       mem_r;
  logic       mem_w;
  wire  [7:0] mem_data_io;

  dmem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

  dmem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_if      (bus_if),
    .mem_add_o   (mem_add),
    .mem_r_o     (mem_r),
    .mem_w_o     (mem_w),
    .mem_data_io (mem_data_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [3:0] a);
    if (a == 4'd0) return 8'hF4;
    if (a == 4'd1) return 8'h03;
    return {4'h1, a};
  endfunction

  // Synchronous memory: registers the addressed word on a read-strobed edge
  // and drives it while the strobe stays high.
  logic [7:0] mem [16];
  logic [7:0] mem_q;
  logic       mem_qv;
  assign mem_data_io = (mem_qv && mem_r) ? mem_q : 8'hzz;

  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(4'(i));
      mem_qv <= 1'b0;
      mem_q  <= 8'h00;
    end else begin
      if (mem_w) mem[mem_add] <= mem_data_io;
      mem_qv <= mem_r;
      if (mem_r) mem_q <= mem[mem_add];
    end
  end

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  txn_t       sb[$];
  logic [7:0] ref_mem [16];
  logic [7:0] exp_rd [2];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   32'({bus_if.gnt1_o, bus_if.gnt0_o}), 32'd0);
    chk({tag, "_done"},  32'({bus_if.done1_o, bus_if.done0_o}), 32'd0);
    chk({tag, "_strb"},  32'({mem_r, mem_w}), 32'd0);
    chk({tag, "_add"},   32'(mem_add), 32'd0);
    chk({tag, "_rd0"},   32'(bus_if.rdata0_o), 32'd0);
    chk({tag, "_rd1"},   32'(bus_if.rdata1_o), 32'd0);
    chk({tag, "_busoe"}, 32'(dut.r_bus_oe), 32'd0);
  endtask

  // Monitor: bus rules every cycle, scoreboard pop on each done pulse.
  int gcnt, rcnt, wcnt;
  initial begin
    txn_t e;
    gcnt = 0; rcnt = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gcnt = 0; rcnt = 0; wcnt = 0;
      end else begin
        if (bus_if.gnt0_o && bus_if.gnt1_o) chk("gnt_excl", 32'd1, 32'd0);
        if (mem_r && mem_w) chk("strobe_excl", 32'd1, 32'd0);
        if (mem_r) chk("bus_oe_during_read", 32'(dut.r_bus_oe), 32'd0);
        gcnt = (bus_if.gnt0_o || bus_if.gnt1_o) ? gcnt + 1 : 0;
        if (mem_r) rcnt++;
        if (mem_w) wcnt++;
        if ((mem_r || mem_w) && sb.size() > 0) begin
          chk("mem_add", 32'(mem_add), 32'(sb[0].addr));
          if (mem_w) chk("wr_bus", 32'(mem_data_io), 32'(sb[0].data));
        end
        if (bus_if.done0_o || bus_if.done1_o) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'({bus_if.done1_o, bus_if.done0_o}), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_port", 32'({bus_if.done1_o, bus_if.done0_o}), e.port ? 32'd2 : 32'd1);
            chk("gnt_owner", 32'({bus_if.gnt1_o, bus_if.gnt0_o}), e.port ? 32'd2 : 32'd1);
            chk("latency", 32'(gcnt), e.we ? 32'd2 : 32'd3);
            chk("strobe_cycles", 32'({rcnt[3:0], wcnt[3:0]}), e.we ? 32'h01 : 32'h20);
            if (!e.we) exp_rd[e.port] = e.data;
          end
          rcnt = 0; wcnt = 0;
        end
        chk("rdata0", 32'(bus_if.rdata0_o), 32'(exp_rd[0]));
        chk("rdata1", 32'(bus_if.rdata1_o), 32'(exp_rd[1]));
      end
    end
  end

  task automatic push(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
    txn_t t;
    t.port = p; t.we = we; t.addr = a;
    t.data = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    sb.push_back(t);
  endtask

  task automatic drive(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
    if (p) begin
      bus_if.req1_i = 1'b1; bus_if.we1_i = we; bus_if.addr1_i = a; bus_if.wdata1_i = d;
    end else begin
      bus_if.req0_i = 1'b1; bus_if.we0_i = we; bus_if.addr0_i = a; bus_if.wdata0_i = d;
    end
  endtask

  // Wait for n done pulses with both requests as driven, then release.
  task automatic wait_dones(input int n, input string name);
    int got = 0;
    for (int k = 0; k < 12 * n && got < n; k++) begin
      @(posedge clk); #1;
      if (bus_if.done0_o || bus_if.done1_o) got++;
    end
    bus_if.req0_i = 1'b0;
    bus_if.req1_i = 1'b0;
    chk({name, "_dones"}, 32'(got), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input bit p, input bit we, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rdata);
    push(p, we, a, d);
    if (!we) sb[$].data = exp_rdata;
    drive(p, we, a, d);
    wait_dones(1, "txn");
  endtask

  vec_t vecs[10];

  initial begin
    logic [3:0] ra;
    logic [7:0] rd;
    bit         rp, rw;

    vecs[0] = '{1'b0, 1'b1, 4'd5, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 4'd5, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 4'd0, 8'h00, 8'hF4};
    vecs[3] = '{1'b1, 1'b0, 4'd1, 8'h00, 8'h03};
    vecs[4] = '{1'b1, 1'b1, 4'd9, 8'h3C, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 4'd9, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 1'b0, 4'd5, 8'h00, 8'hA5};
    vecs[7] = '{1'b0, 1'b1, 4'd0, 8'h5A, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 4'd0, 8'h00, 8'h5A};
    vecs[9] = '{1'b0, 1'b0, 4'd2, 8'h00, 8'h77};

    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(4'(i));
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    bus_if.req0_i = 1'b0; bus_if.we0_i = 1'b0; bus_if.addr0_i = '0; bus_if.wdata0_i = '0;
    bus_if.req1_i = 1'b0; bus_if.we1_i = 1'b0; bus_if.addr1_i = '0; bus_if.wdata1_i = '0;
    rst_n = 1'b0; mem_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    mem_rst = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both ports raised together and held: order 0,1,0,1.
    push(1'b0, 1'b1, 4'd2, 8'h77);
    push(1'b1, 1'b0, 4'd1, 8'h00);
    push(1'b0, 1'b1, 4'd2, 8'h77);
    push(1'b1, 1'b0, 4'd1, 8'h00);
    drive(1'b0, 1'b1, 4'd2, 8'h77);
    drive(1'b1, 1'b0, 4'd1, 8'h00);
    wait_dones(4, "contend");
    chk("contend_sb", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      $display("vec %0d: port=%0d we=%0d addr=%0d wdata=0x%0h exp_rdata=0x%0h",
               i, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    for (int i = 0; i < 16; i++) begin
      rp = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 255));
      run_txn(rp, rw, ra, rd, ref_mem[ra]);
      $display("rand %0d: port=%0d we=%0d addr=%0d data=0x%0h", i, rp, rw, ra, rw ? rd : ref_mem[ra]);
    end

    // Abort a port 1 read in RD_DATA.
    push(1'b1, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b0, 4'd0, 8'h00);
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_abort_rd", 32'({mem_r, bus_if.gnt1_o}), 32'd3);
    rst_n = 1'b0;
    bus_if.req1_i = 1'b0;
    #1;
    chk_reset_outputs("abort");
    sb.delete();
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(1'b0, 1'b0, 4'd5, 8'h00);
    push(1'b1, 1'b0, 4'd0, 8'h00);
    drive(1'b0, 1'b0, 4'd5, 8'h00);
    drive(1'b1, 1'b0, 4'd0, 8'h00);
    wait_dones(2, "post_abort");
    $display("abort: tie after reset served port 0 then port 1");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
